// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and helpers for the iterative shifter
package shift_pkg;

    typedef enum logic [1:0] {
        LSR = 2'b00,
        LSL = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_e;

    function automatic int unsigned clamp_shamt(input int unsigned shamt, input int unsigned limit);
        return (shamt > limit) ? limit : shamt;
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift by k (0..STEP); rotate only with SHIFT_ROTATE_EN
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STEP       = 1,
    parameter int KW         = $clog2(STEP + 1)
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [KW-1:0]         k,
    input  logic [1:0]            mode,
    input  logic                  sign,
    output logic [DATA_WIDTH-1:0] next_value,
    output logic                  carry
);

    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    logic [DATA_WIDTH-1:0] right;
    logic [DATA_WIDTH-1:0] out_r;
    logic [DATA_WIDTH-1:0] out_l;

    always_comb begin
        right      = value >> k;
        // last bit leaving the word: bit k-1 for right moves, bit W-k for left
        out_r      = value >> (k - KW'(1));
        out_l      = value << (k - KW'(1));
        next_value = value;
        carry      = 1'b0;
        case (mode)
            LSR: begin
                next_value = right;
                carry      = out_r[0];
            end
            LSL: begin
                next_value = value << k;
                carry      = out_l[DATA_WIDTH-1];
            end
            ASR: begin
                next_value = right | (sign ? ~(ONES >> k) : '0);
                carry      = out_r[0];
            end
`ifdef SHIFT_ROTATE_EN
            ROR: begin
                next_value = right | (value << (DATA_WIDTH - int'(k)));
                carry      = out_r[0];
            end
`endif
            default: begin
                next_value = value;
                carry      = 1'b0;
            end
        endcase
        if (k == '0) carry = 1'b0;
    end

endmodule

// File: rtl/shift_unit_iter.sv
// rtl/shift_unit_iter.sv - multi-cycle shifter, STEP bits per cycle; SHIFT_ROTATE_EN enables ROR
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int STEP        = 1,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  OPERAND,
    input  logic [SHAMT_WIDTH-1:0] SHAMT,
    input  logic [1:0]             MODE,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_carry,
    output logic                   out_err
);

    localparam int KW = $clog2(STEP + 1);

    shift_state_e          state, state_next;
    shift_mode_e           mode_q;
    logic [DATA_WIDTH-1:0] value;
    logic                  carry;
    logic                  err;
    logic                  sign;
    logic [SHAMT_WIDTH-1:0] rem;
    logic [SHAMT_WIDTH-1:0] eff;
    logic                  illegal;
    logic [KW-1:0]         k;
    logic [DATA_WIDTH-1:0] step_value;
    logic                  step_carry;

    always_comb begin
        illegal = 1'b0;
        eff     = SHAMT_WIDTH'(clamp_shamt(32'(SHAMT), DATA_WIDTH));
`ifdef SHIFT_ROTATE_EN
        if (MODE == ROR) eff = SHAMT_WIDTH'(32'(SHAMT) % 32'(DATA_WIDTH));
`else
        illegal = (MODE == ROR);
`endif
        k = (rem < SHAMT_WIDTH'(STEP)) ? KW'(rem) : KW'(STEP);
    end

    shift_step #(
        .DATA_WIDTH(DATA_WIDTH),
        .STEP      (STEP),
        .KW        (KW)
    ) u_step (
        .value     (value),
        .k         (k),
        .mode      (mode_q),
        .sign      (sign),
        .next_value(step_value),
        .carry     (step_carry)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (illegal || eff == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (rem <= SHAMT_WIDTH'(STEP)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            value  <= '0;
            carry  <= 1'b0;
            err    <= 1'b0;
            sign   <= 1'b0;
            mode_q <= LSR;
            rem    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    value  <= illegal ? '0 : OPERAND;
                    carry  <= 1'b0;
                    err    <= illegal;
                    sign   <= OPERAND[DATA_WIDTH-1];
                    mode_q <= shift_mode_e'(MODE);
                    rem    <= illegal ? '0 : eff;
                end
                SHIFT: begin
                    value <= step_value;
                    carry <= step_carry;
                    rem   <= rem - SHAMT_WIDTH'(k);
                end
                default: ;
            endcase
        end
    end

    assign out_data  = value;
    assign out_carry = carry;
    assign out_err   = err;

endmodule

// File: tb/tb_shift_unit_iter.sv
// tb/tb_shift_unit_iter.sv - scoreboard bench for shift_unit_iter at STEP=1 and STEP=4
module tb_shift_unit_iter;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        logic         err;
        int           lat;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic         out_carry [2];
    logic         out_err   [2];
    logic [W-1:0] operand   [2];
    logic [W-1:0] out_data  [2];
    logic [4:0]   shamt     [2];
    logic [1:0]   mode      [2];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    shift_unit_iter #(.DATA_WIDTH(W), .STEP(1), .SHAMT_WIDTH(5)) u_dut_s1 (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .OPERAND(operand[0]), .SHAMT(shamt[0]), .MODE(mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_carry(out_carry[0]), .out_err(out_err[0])
    );

    shift_unit_iter #(.DATA_WIDTH(W), .STEP(4), .SHAMT_WIDTH(5)) u_dut_s4 (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .OPERAND(operand[1]), .SHAMT(shamt[1]), .MODE(mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_carry(out_carry[1]), .out_err(out_err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // bit-serial reference: one bit per iteration regardless of STEP
    function automatic exp_t model(input logic [W-1:0] op, input logic [4:0] sh,
                                   input logic [1:0] md, input int step);
        exp_t         e;
        int           eff;
        logic [W-1:0] v;
        logic         c;
        v = op;
        c = 1'b0;
        e.err = 1'b0;
`ifndef SHIFT_ROTATE_EN
        if (md == 2'b11) begin
            e.data = '0; e.carry = 1'b0; e.err = 1'b1; e.lat = 1;
            return e;
        end
`endif
        eff = (md == 2'b11) ? int'(sh) % W : ((int'(sh) > W) ? W : int'(sh));
        for (int i = 0; i < eff; i++) begin
            case (md)
                2'b00: begin c = v[0];   v = {1'b0, v[W-1:1]}; end
                2'b01: begin c = v[W-1]; v = {v[W-2:0], 1'b0}; end
                2'b10: begin c = v[0];   v = {op[W-1], v[W-1:1]}; end
                default: begin c = v[0]; v = {v[0], v[W-1:1]}; end
            endcase
        end
        e.data  = v;
        e.carry = c;
        e.lat   = (eff == 0) ? 1 : (eff + step - 1) / step + 1;
        return e;
    endfunction

    task automatic run_txn(input int d, input logic [W-1:0] op, input logic [4:0] sh,
                           input logic [1:0] md, input int hold);
        exp_t e;
        int   lat;
        int   cyc;
        @(negedge CLK);
        check_eq("in_ready_idle", 32'(in_ready[d]), 32'd1);
        operand[d]   = op;
        shamt[d]     = sh;
        mode[d]      = md;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b0;
        sb.push_back(model(op, sh, md, (d == 0) ? 1 : 4));
        @(posedge CLK);
        #1 in_valid[d] = 1'b0;
        lat = 1;
        cyc = 0;
        @(negedge CLK);
        while (!out_valid[d] && cyc < 100) begin
            @(negedge CLK);
            lat++;
            cyc++;
        end
        if (!out_valid[d]) check_eq("out_valid_timeout", 32'd0, 32'd1);
        e = sb.pop_front();
        check_eq("data",    32'(out_data[d]),  32'(e.data));
        check_eq("carry",   32'(out_carry[d]), 32'(e.carry));
        check_eq("err",     32'(out_err[d]),   32'(e.err));
        check_eq("latency", 32'(lat),          32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check_eq("hold_valid", 32'(out_valid[d]), 32'd1);
            check_eq("hold_data",  32'(out_data[d]),  32'(e.data));
            check_eq("hold_carry", 32'(out_carry[d]), 32'(e.carry));
            check_eq("hold_ready", 32'(in_ready[d]),  32'd0);
        end
        out_ready[d] = 1'b1;
        @(posedge CLK);
        #1 out_ready[d] = 1'b0;
        @(negedge CLK);
        check_eq("post_hs_in_ready",  32'(in_ready[d]),  32'd1);
        check_eq("post_hs_out_valid", 32'(out_valid[d]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0;
            operand[d] = '0; shamt[d] = '0; mode[d] = '0;
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_in_ready",  32'(in_ready[d]),  32'd1);
            check_eq("rst_out_valid", 32'(out_valid[d]), 32'd0);
            check_eq("rst_out_data",  32'(out_data[d]),  32'd0);
            check_eq("rst_out_carry", 32'(out_carry[d]), 32'd0);
            check_eq("rst_out_err",   32'(out_err[d]),   32'd0);
        end
        RST = 1'b1;

        run_txn(0, 16'hA5A5, 5'd4,  2'b00, 0);
        run_txn(1, 16'h8001, 5'd3,  2'b10, 0);
        run_txn(1, 16'h8001, 5'd1,  2'b01, 0);
        run_txn(1, 16'h00FF, 5'd20, 2'b01, 0);
        run_txn(0, 16'h00FF, 5'd20, 2'b01, 0);
        run_txn(1, 16'h8000, 5'd31, 2'b10, 0);
        run_txn(0, 16'h1234, 5'd16, 2'b00, 0);
        for (int m = 0; m < 4; m++) begin
            run_txn(0, 16'hBEEF, 5'd0, 2'(m), 0);
            run_txn(1, 16'hBEEF, 5'd0, 2'(m), 0);
        end
        run_txn(0, 16'h0001, 5'd1,  2'b11, 0);
        run_txn(0, 16'h0001, 5'd17, 2'b11, 0);
        run_txn(1, 16'h0001, 5'd17, 2'b11, 0);
        run_txn(1, 16'hC3A5, 5'd6,  2'b11, 0);
        run_txn(0, 16'hF00D, 5'd5,  2'b10, 10);

        // abort a long shift with reset; no result must appear
        @(negedge CLK);
        operand[0] = 16'hFFFF; shamt[0] = 5'd16; mode[0] = 2'b01; in_valid[0] = 1'b1;
        @(posedge CLK);
        #1 in_valid[0] = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_eq("abort_out_valid", 32'(out_valid[0]), 32'd0);
        check_eq("abort_out_data",  32'(out_data[0]),  32'd0);
        check_eq("abort_out_carry", 32'(out_carry[0]), 32'd0);
        check_eq("abort_in_ready",  32'(in_ready[0]),  32'd1);
        @(negedge CLK);
        RST = 1'b1;
        run_txn(0, 16'h0F0F, 5'd3, 2'b01, 0);

        for (int i = 0; i < 20; i++) begin
            run_txn(int'($urandom_range(0, 1)), 16'($urandom), 5'($urandom_range(0, 31)),
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
